ball_game_ctrl: RTL and testbench
=================================

Name: ball_game_ctrl

Overview:
Game sequencer for the ball sprites. It runs the round state machine (idle, serve, play, over) and drives the shared game_state bus plus a per-ball hold, so ball instances are held at their spawn position outside play. It schedules difficulty by enabling extra balls and shortening the movement time constant per level. It aggregates the balls' collision flags into a single game-over and keeps the survival score. It sits between the input/button logic and the ball instances, at top level next to the VGA renderer.

Parameters:
NUM_BALLS, 4, number of ball instances controlled (1..8)
TICK_DIV, 50000000, CLOCK_50 cycles per score tick (1 s)
SERVE_CYCLES, 25000000, cycles spent in SERVE before play (0.5 s)
LEVEL_SECS, 10, score ticks per level step
MAX_LEVEL, 7, highest level (4-bit)
BASE_TIME_CONST, 1000, ball_time_const at level 0
TIME_CONST_STEP, 100, decrement per level
MIN_TIME_CONST, 200, floor for ball_time_const

Ports:
CLOCK_50  in  1  50 MHz system clock
reset  in  1  synchronous, active-low
start  in  1  start button, active-high, already synchronized; rising edge acts
hit_flags  in  NUM_BALLS  bit i = game_over_flag[0] of ball i (sticky until ball reset)
game_state  out  4  0=PLAY, 1=IDLE, 2=SERVE, 3=OVER; nonzero holds balls in reset
ball_hold  out  NUM_BALLS  per-ball hold; high = ball i held at spawn
ball_enable  out  NUM_BALLS  ball i participates in the current level
ball_time_const  out  32  movement period for all balls
level  out  4  current difficulty level
score  out  16  seconds survived in the current round
game_over  out  1  high while in OVER

Behaviour:
- Registered outputs. Reset (reset=0 at a clock edge) puts every output to its value below in the same edge, from any state including mid-PLAY:
  - state IDLE, game_state=1
  - ball_hold all 1s
  - ball_enable=...0001
  - ball_time_const=BASE_TIME_CONST
  - level=0, score=0, game_over=0
  - prescaler, serve counter and level-seconds counter all 0
- start edge detect: start_q register; start_rise = start & ~start_q. A held start produces one event only.
- IDLE: on start_rise, go to SERVE next cycle. Clear score, level, time_const and counters in that same transition.
- SERVE:
  - game_state=2, all balls held.
  - Serve counter counts up to SERVE_CYCLES-1, then PLAY on the next edge.
  - start is ignored in SERVE.
- PLAY:
  - game_state=0.
  - ball_hold[i] = ~ball_enable[i].
  - Prescaler counts 0..TICK_DIV-1. On wrap it emits a tick: score+1 (saturating at 16'hFFFF) and level-seconds counter +1.
  - When the level-seconds counter reaches LEVEL_SECS and level<MAX_LEVEL: level+1, counter cleared, and ball_time_const = max(MIN_TIME_CONST, ball_time_const - TIME_CONST_STEP). Compute the max without unsigned underflow: if current < MIN+STEP, load MIN.
  - At MAX_LEVEL the counter keeps wrapping, but level and time_const hold.
- ball_enable[i] = (i <= level), so one extra ball is enabled per level until all NUM_BALLS are enabled. A newly enabled ball is released from hold the cycle after the level update.
- Hit detect: hit = |(hit_flags & ball_enable), evaluated only in PLAY. On hit, go to OVER next edge.
  - Hit has priority over a simultaneous tick: no score or level increment that cycle.
  - Flags from disabled balls are ignored.
- OVER:
  - game_state=3, game_over=1, all balls held. Holding clears the balls' sticky flags.
  - score and level are frozen for display.
  - On start_rise, go to SERVE with score, level, time_const and counters cleared as in the IDLE exit. game_over drops on entry to SERVE.
- There is no path back to IDLE except reset.
- Counters are sized by $clog2 of their limits. score is 16-bit. level is 4-bit; MAX_LEVEL must be at most 15.

Test Plan:
All scenarios use TICK_DIV=10, SERVE_CYCLES=5, LEVEL_SECS=2, NUM_BALLS=4, BASE=1000, STEP=100, MIN=200.
1. Reset then idle, with start held low for 50 cycles -> game_state=1, ball_hold=4'b1111, ball_enable=4'b0001, time_const=1000, score=0.
2. Round start: one-cycle start pulse -> game_state=2 the next cycle, then 0 exactly 5 cycles later; ball_hold=4'b1110.
3. Level ramp: no hits for 60 cycles in PLAY -> score=6, level=3, time_const=700, ball_enable=4'b1111, ball_hold=4'b0000. Continue to level 7 -> time_const=300. Force BASE=250 -> the first level step gives 200 (floor), not an underflow.
4. Hit handling:
   - hit_flags=4'b1000 at level 0 -> ignored, stays PLAY.
   - hit_flags=4'b0001 -> game_state=3 and game_over=1 next cycle, score frozen, ball_hold=4'b1111.
   - hit asserted on a tick cycle -> score not incremented.
5. Restart from OVER:
   - start held high across entry to OVER -> no restart.
   - start released then pulsed -> SERVE with score=0, level=0, time_const=1000.
6. Reset mid-PLAY at level 2 -> all outputs return to the reset values on the next edge, and the FSM returns to IDLE.

Source files
------------

// File: rtl/ball_game_ctrl.sv
// ball_game_ctrl: round sequencer, difficulty ramp, hit aggregation and survival score for the ball sprites
module ball_game_ctrl #(
    parameter int NUM_BALLS       = 4,
    parameter int TICK_DIV        = 50000000,
    parameter int SERVE_CYCLES    = 25000000,
    parameter int LEVEL_SECS      = 10,
    parameter int MAX_LEVEL       = 7,
    parameter int BASE_TIME_CONST = 1000,
    parameter int TIME_CONST_STEP = 100,
    parameter int MIN_TIME_CONST  = 200
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_BALLS-1:0] hit_flags,
    output logic [3:0]           game_state,
    output logic [NUM_BALLS-1:0] ball_hold,
    output logic [NUM_BALLS-1:0] ball_enable,
    output logic [31:0]          ball_time_const,
    output logic [3:0]           level,
    output logic [15:0]          score,
    output logic                 game_over
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = SERVE_CYCLES > 1 ? $clog2(SERVE_CYCLES) : 1;
    localparam int LW = LEVEL_SECS > 1 ? $clog2(LEVEL_SECS) : 1;

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_IDLE  = 2'd1,
        S_SERVE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t        state;
    logic          start_q;
    logic [TW-1:0] pre_cnt;
    logic [SW-1:0] serve_cnt;
    logic [LW-1:0] sec_cnt;
    logic          start_rise;
    logic          hit;
    logic          tick;
    logic          sec_wrap;
    logic          level_up;
    logic [31:0]   next_tc;

    function automatic logic [NUM_BALLS-1:0] en_mask(input logic [3:0] lvl);
        logic [NUM_BALLS-1:0] m;
        for (int i = 0; i < NUM_BALLS; i++) m[i] = 4'(i) <= lvl;
        return m;
    endfunction

    // Event decode: start edge, enabled-ball hit, second tick, level step and floored time constant
    always_comb begin
        start_rise = start & ~start_q;
        hit        = |(hit_flags & ball_enable);
        tick       = pre_cnt == TW'(TICK_DIV - 1);
        sec_wrap   = sec_cnt == LW'(LEVEL_SECS - 1);
        level_up   = sec_wrap && level < 4'(MAX_LEVEL);
        next_tc    = ball_time_const < 32'(MIN_TIME_CONST + TIME_CONST_STEP) ? 32'(MIN_TIME_CONST)
                                                                             : ball_time_const - 32'(TIME_CONST_STEP);
    end

    // Round FSM with all outputs registered alongside the state
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state           <= S_IDLE;
            game_state      <= 4'd1;
            ball_hold       <= '1;
            ball_enable     <= en_mask(4'd0);
            ball_time_const <= 32'(BASE_TIME_CONST);
            level           <= '0;
            score           <= '0;
            game_over       <= 1'b0;
            pre_cnt         <= '0;
            serve_cnt       <= '0;
            sec_cnt         <= '0;
            start_q         <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start_rise) begin
                        state           <= S_SERVE;
                        game_state      <= 4'd2;
                        ball_hold       <= '1;
                        ball_enable     <= en_mask(4'd0);
                        ball_time_const <= 32'(BASE_TIME_CONST);
                        level           <= '0;
                        score           <= '0;
                        game_over       <= 1'b0;
                        pre_cnt         <= '0;
                        serve_cnt       <= '0;
                        sec_cnt         <= '0;
                    end
                end
                S_SERVE: begin
                    if (serve_cnt == SW'(SERVE_CYCLES - 1)) begin
                        state      <= S_PLAY;
                        game_state <= 4'd0;
                        ball_hold  <= ~ball_enable;
                    end else begin
                        serve_cnt <= serve_cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        state      <= S_OVER;
                        game_state <= 4'd3;
                        game_over  <= 1'b1;
                        ball_hold  <= '1;
                    end else begin
                        ball_hold <= ~ball_enable;
                        pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
                        if (tick) begin
                            score   <= score == 16'hFFFF ? score : score + 16'd1;
                            sec_cnt <= sec_wrap ? '0 : sec_cnt + 1'b1;
                            if (level_up) begin
                                level           <= level + 4'd1;
                                ball_enable     <= en_mask(level + 4'd1);
                                ball_time_const <= next_tc;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_game_ctrl.sv
// tb_ball_game_ctrl: randomized scoreboard bench against a round-level reference model
module tb_ball_game_ctrl;
    localparam int NB = 4, TD = 10, SC = 5, LS = 2, ML = 7;
    localparam int BASE = 1000, BASEB = 250, STEP = 100, MINC = 200;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  hit_flags = '0;
    logic [3:0]  game_state, ball_hold, ball_enable, level;
    logic [31:0] ball_time_const;
    logic [15:0] score;
    logic        game_over;
    logic [3:0]  game_state_b, ball_hold_b, ball_enable_b, level_b;
    logic [31:0] ball_time_const_b;
    logic [15:0] score_b;
    logic        game_over_b;

    ball_game_ctrl #(.NUM_BALLS(NB), .TICK_DIV(TD), .SERVE_CYCLES(SC), .LEVEL_SECS(LS), .MAX_LEVEL(ML),
                     .BASE_TIME_CONST(BASE), .TIME_CONST_STEP(STEP), .MIN_TIME_CONST(MINC)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .hit_flags(hit_flags),
        .game_state(game_state), .ball_hold(ball_hold), .ball_enable(ball_enable),
        .ball_time_const(ball_time_const), .level(level), .score(score), .game_over(game_over));

    ball_game_ctrl #(.NUM_BALLS(NB), .TICK_DIV(TD), .SERVE_CYCLES(SC), .LEVEL_SECS(LS), .MAX_LEVEL(ML),
                     .BASE_TIME_CONST(BASEB), .TIME_CONST_STEP(STEP), .MIN_TIME_CONST(MINC)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .hit_flags(hit_flags),
        .game_state(game_state_b), .ball_hold(ball_hold_b), .ball_enable(ball_enable_b),
        .ball_time_const(ball_time_const_b), .level(level_b), .score(score_b), .game_over(game_over_b));

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [3:0]  gs;
        logic [3:0]  hold;
        logic [3:0]  en;
        logic [31:0] tc;
        logic [31:0] tcb;
        logic [3:0]  lvl;
        logic [15:0] sc;
        logic        go;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   checks = 0;
    int   errors = 0;
    int   ph = 1;
    int   serve_edges = 0;
    int   play_edges = 0;
    bit   pst = 1'b0;
    logic [3:0] hold_m = 4'hf;

    function automatic int lvl_of(input int pe);
        int l;
        l = (pe / TD) / LS;
        return l > ML ? ML : l;
    endfunction

    function automatic logic [3:0] mask(input int l);
        logic [3:0] r;
        for (int i = 0; i < NB; i++) r[i] = i <= l;
        return r;
    endfunction

    function automatic logic [31:0] tc_of(input int base, input int l);
        int t;
        t = base - STEP * l;
        return 32'(t < MINC ? MINC : t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input logic [3:0] hf);
        int   lb;
        int   lv;
        bit   rise;
        exp_t e;
        reset = r;
        start = s;
        hit_flags = hf;
        @(posedge CLOCK_50);
        lb = lvl_of(play_edges);
        if (!r) begin
            ph = 1;
            serve_edges = 0;
            play_edges = 0;
            pst = 1'b0;
            hold_m = 4'hf;
        end else begin
            rise = s && !pst;
            pst = s;
            if ((ph == 1 || ph == 3) && rise) begin
                ph = 2;
                serve_edges = 0;
                play_edges = 0;
            end else if (ph == 2) begin
                serve_edges++;
                if (serve_edges == SC) ph = 0;
            end else if (ph == 0) begin
                if ((hf & mask(lb)) != 4'd0) ph = 3;
                else play_edges++;
            end
            hold_m = ph == 0 ? ~mask(lb) : 4'hf;
        end
        lv = lvl_of(play_edges);
        e.gs = 4'(ph);
        e.hold = hold_m;
        e.en = mask(lv);
        e.tc = tc_of(BASE, lv);
        e.tcb = tc_of(BASEB, lv);
        e.lvl = 4'(lv);
        e.sc = 16'(play_edges / TD > 65535 ? 65535 : play_edges / TD);
        e.go = ph == 3;
        q.push_back(e);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (q.size() > 0) begin
                m = q.pop_front();
                chk("game_state", 32'(game_state), 32'(m.gs));
                chk("ball_hold", 32'(ball_hold), 32'(m.hold));
                chk("ball_enable", 32'(ball_enable), 32'(m.en));
                chk("time_const", ball_time_const, m.tc);
                chk("level", 32'(level), 32'(m.lvl));
                chk("score", 32'(score), 32'(m.sc));
                chk("game_over", 32'(game_over), 32'(m.go));
                chk("b_game_state", 32'(game_state_b), 32'(m.gs));
                chk("b_ball_hold", 32'(ball_hold_b), 32'(m.hold));
                chk("b_ball_enable", 32'(ball_enable_b), 32'(m.en));
                chk("b_time_const_floor", ball_time_const_b, m.tcb);
                chk("b_level", 32'(level_b), 32'(m.lvl));
                chk("b_score", 32'(score_b), 32'(m.sc));
                chk("b_game_over", 32'(game_over_b), 32'(m.go));
            end
        end
    end

    initial begin
        bit r;
        bit s;
        logic [3:0] hf;
        repeat (3) step(1'b0, 1'b0, 4'd0);
        repeat (50) step(1'b1, 1'b0, 4'($urandom));
        step(1'b1, 1'b1, 4'd0);
        repeat (SC + 1) step(1'b1, 1'b0, 4'd0);
        repeat (150) step(1'b1, 1'b0, 4'($urandom) & ~mask(lvl_of(play_edges)));
        step(1'b1, 1'b1, 4'd0);
        for (int i = 0; i < TD && play_edges % TD != TD - 1; i++) step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'(1 << $urandom_range(3, 0)));
        repeat (5) step(1'b1, 1'b1, 4'hf);
        repeat (3) step(1'b1, 1'b0, 4'hf);
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        repeat (SC + 45) step(1'b1, 1'b0, 4'($urandom) & ~mask(lvl_of(play_edges)));
        step(1'b0, 1'b0, 4'd0);
        repeat (3) step(1'b1, 1'b0, 4'd0);
        repeat (3000) begin
            r = $urandom_range(199, 0) != 0;
            s = $urandom_range(7, 0) == 0;
            hf = $urandom_range(29, 0) == 0 ? 4'($urandom) : 4'($urandom) & ~mask(lvl_of(play_edges));
            step(r, s, hf);
        end
        repeat (2) @(negedge CLOCK_50);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
